// File: rtl/calc_pkg.sv
// Shared calculator types and constants.
// Used by the digit accumulator and the radix MAC.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_RADIX = 10;

    // Largest magnitude an operand of out_w bits may hold.
    function automatic logic [63:0] calc_limit(
        input int out_w,
        input bit signed_mode
    );
        logic [63:0] one;
        one = 64'd1;
        if (signed_mode)
            return (one << (out_w - 1)) - one;
        return (one << out_w) - one;
    endfunction

endpackage

// File: rtl/radix_mac.sv
// Combinational acc*RADIX+digit with limit and legality check.
// Product is kept OUT_W+IN_W wide so it cannot wrap before the compare.
module radix_mac
    import calc_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 8,
    parameter int RADIX  = DEF_RADIX,
    parameter bit SIGNED = 1'b1
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  digit,
    output logic [OUT_W-1:0] next_acc,
    output logic             reject
);

    localparam int PW = OUT_W + IN_W;
    localparam logic [PW-1:0] RAD_W = PW'(RADIX);
    localparam logic [PW-1:0] LIM_W = PW'(calc_limit(OUT_W, SIGNED));
    localparam logic [IN_W:0] RAD_D = (IN_W + 1)'(RADIX);

    logic [PW-1:0] wide;
    logic          illegal;
    logic          over;

    always_comb begin
        wide    = {{IN_W{1'b0}}, acc} * RAD_W
                + {{OUT_W{1'b0}}, digit};
        illegal = {1'b0, digit} >= RAD_D;
        over    = wide > LIM_W;
        reject  = illegal || over;
        next_acc = wide[OUT_W-1:0];
    end

endmodule

// File: rtl/digit_accumulator.sv
// Keypad digit stream to binary operand, with sign entry.
// Value is presented on a valid/ready port until taken.
module digit_accumulator
    import calc_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int OUT_W      = 8,
    parameter int RADIX      = DEF_RADIX,
    parameter int MAX_DIGITS = 3,
    parameter bit SIGNED     = 1'b1,
    localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  digit_in,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic             neg_toggle,
    input  logic             commit,
    input  logic             clear,
    output logic [OUT_W-1:0] value_out,
    output logic             value_valid,
    input  logic             value_ready,
    output logic [CW-1:0]    digit_count,
    output logic             neg,
    output logic             err
);

    state_t           state_q;
    state_t           state_n;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_n;
    logic [CW-1:0]    cnt_n;
    logic             neg_n;
    logic             err_n;
    logic [OUT_W-1:0] vout_n;
    logic             vvalid_n;
    logic [OUT_W-1:0] mac_acc;
    logic             mac_rej;
    logic             take;

    radix_mac #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .RADIX (RADIX),
        .SIGNED(SIGNED)
    ) u_mac (
        .acc     (acc_q),
        .digit   (digit_in),
        .next_acc(mac_acc),
        .reject  (mac_rej)
    );

    assign digit_ready = rst_n && (state_q != HOLD)
                       && (digit_count < CW'(MAX_DIGITS))
                       && !clear;
    assign take = digit_valid && digit_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            digit_count <= '0;
            neg         <= 1'b0;
            err         <= 1'b0;
            value_out   <= '0;
            value_valid <= 1'b0;
        end else begin
            state_q     <= state_n;
            acc_q       <= acc_n;
            digit_count <= cnt_n;
            neg         <= neg_n;
            err         <= err_n;
            value_out   <= vout_n;
            value_valid <= vvalid_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        acc_n    = acc_q;
        cnt_n    = digit_count;
        neg_n    = neg;
        err_n    = err;
        vout_n   = value_out;
        vvalid_n = value_valid;
        if (clear) begin
            state_n  = IDLE;
            acc_n    = '0;
            cnt_n    = '0;
            neg_n    = 1'b0;
            err_n    = 1'b0;
            vout_n   = '0;
            vvalid_n = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (value_ready) begin
                        state_n  = IDLE;
                        acc_n    = '0;
                        cnt_n    = '0;
                        neg_n    = 1'b0;
                        vvalid_n = 1'b0;
                    end
                end
                default: begin
                    if (take) begin
                        if (mac_rej) begin
                            err_n = 1'b1;
                        end else begin
                            acc_n   = mac_acc;
                            cnt_n   = digit_count + 1'b1;
                            state_n = ENTRY;
                        end
                    end
                    if (neg_toggle && SIGNED)
                        neg_n = ~neg;
                    // same-cycle digit and sign are part of the result
                    if (commit) begin
                        vout_n   = neg_n ? (~acc_n + 1'b1) : acc_n;
                        vvalid_n = 1'b1;
                        state_n  = HOLD;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_accumulator.sv
// Bench for digit_accumulator: arithmetic reference model,
// queue scoreboard on the value port, per-cycle status checks.
module tb_digit_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_in = '0;
    logic       digit_valid = 1'b0;
    logic       digit_ready;
    logic       neg_toggle = 1'b0;
    logic       commit = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] value_out;
    logic       value_valid;
    logic       value_ready = 1'b1;
    logic [1:0] digit_count;
    logic       neg;
    logic       err;

    int total = 0;
    int bad = 0;

    int m_acc = 0;
    int m_cnt = 0;
    bit m_neg = 0;
    bit m_err = 0;
    bit m_hold = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    digit_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_in   (digit_in),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready),
        .neg_toggle (neg_toggle),
        .commit     (commit),
        .clear      (clear),
        .value_out  (value_out),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .digit_count(digit_count),
        .neg        (neg),
        .err        (err)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return rst_n && !m_hold && (m_cnt < 3) && !clear;
    endfunction

    // Reference: operand entry rules in plain integer arithmetic.
    task automatic model_edge();
        bit rdy;
        int cand;
        rdy = m_ready();
        if (clear) begin
            if (m_hold && exp_q.size() > 0)
                void'(exp_q.pop_front());
            m_acc = 0; m_cnt = 0; m_neg = 0; m_err = 0; m_hold = 0;
        end else if (m_hold) begin
            if (value_ready) begin
                m_acc = 0; m_cnt = 0; m_neg = 0; m_hold = 0;
            end
        end else begin
            if (digit_valid && rdy) begin
                cand = m_acc * 10 + int'(digit_in);
                if (digit_in >= 10 || cand > 127)
                    m_err = 1;
                else begin
                    m_acc = cand;
                    m_cnt++;
                end
            end
            if (neg_toggle) m_neg = !m_neg;
            if (commit) begin
                exp_q.push_back(m_neg ? ((256 - m_acc) % 256) : m_acc);
                m_hold = 1;
            end
        end
    endtask

    task automatic step(input bit dv, input int d, input bit nt,
                        input bit cm, input bit cl, input bit vr);
        digit_valid = dv;
        digit_in    = 4'(d);
        neg_toggle  = nt;
        commit      = cm;
        clear       = cl;
        value_ready = vr;
        @(negedge clk);
        chk("digit_ready", int'(digit_ready), int'(m_ready()));
        chk("digit_count", int'(digit_count), m_cnt);
        chk("neg", int'(neg), int'(m_neg));
        chk("err", int'(err), int'(m_err));
        chk("value_valid", int'(value_valid), int'(m_hold));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic dig(input int d);
        step(1, d, 0, 0, 0, 1);
    endtask

    task automatic idle(input bit vr);
        step(0, 0, 0, 0, 0, vr);
    endtask

    // Scoreboard monitor on the value port.
    always @(negedge clk) begin
        if (rst_n && value_valid && !clear) begin
            if (exp_q.size() == 0) begin
                chk("value_unexpected", int'(value_out), -1);
            end else if (value_ready) begin
                chk("value_out", int'(value_out), exp_q.pop_front());
            end else begin
                chk("value_hold", int'(value_out), exp_q[0]);
            end
        end
    end

    initial begin
        #2;
        chk("rst_ready", int'(digit_ready), 0);
        chk("rst_value", int'(value_out), 0);
        chk("rst_valid", int'(value_valid), 0);
        chk("rst_count", int'(digit_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        dig(1); dig(2); dig(7);
        step(0, 0, 0, 1, 0, 1);
        idle(1); idle(1);

        dig(1); dig(2); dig(8); dig(0);
        step(0, 0, 0, 1, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 1, 1);

        step(0, 0, 1, 0, 0, 1);
        dig(5); dig(0);
        step(0, 0, 0, 1, 0, 1);
        idle(1); idle(1);

        step(0, 0, 0, 0, 1, 1);
        dig(10); dig(4); dig(2);
        step(0, 0, 0, 1, 0, 0);
        idle(0); idle(0); idle(0);
        step(1, 3, 0, 0, 0, 1);
        idle(1);

        dig(9); dig(9);
        step(0, 0, 0, 1, 1, 1);
        idle(1);
        chk("clear_acc", int'(dut.acc_q), 0);

        dig(3);
        digit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(digit_count), 0);
        chk("arst_ready", int'(digit_ready), 0);
        chk("arst_valid", int'(value_valid), 0);
        #1 rst_n = 1'b1;
        m_acc = 0; m_cnt = 0; m_neg = 0; m_err = 0; m_hold = 0;
        exp_q.delete();
        @(posedge clk); #1;
        dig(6);
        step(0, 0, 0, 1, 0, 1);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            bit cm;
            cm = ($urandom_range(0, 99) < 15);
            step($urandom_range(0, 99) < 60,
                 int'($urandom_range(0, 11)),
                 !cm && ($urandom_range(0, 99) < 10),
                 cm,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 70);
        end
        for (int i = 0; i < 3; i++) idle(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_accumulator.md
Name: digit_accumulator

Overview:
- Converts a stream of keypad digit codes (IN_W bits each) into one OUT_W-bit binary operand for the calculator ALU.
- Computes acc = acc*RADIX + digit per accepted digit, optionally negated (two's complement) at commit.
- Sits between the keypad decoder (valid/ready digit stream) and the operand register or ALU input (valid/ready value stream).
- Generalised successor of the fixed 4-to-8-bit widening step: parametrised widths, radix, digit limit and signed mode, with stateful entry.

Parameters:
- IN_W, 4, width of each digit code.
- OUT_W, 8, width of the produced operand.
- RADIX, 10, entry base; legal digit codes are 0..RADIX-1, RADIX ≤ 2^IN_W.
- MAX_DIGITS, 3, maximum accepted digits per operand.
- SIGNED, 1, 1 means the sign toggle is honoured and the limit is 2^(OUT_W-1)-1; 0 means the limit is 2^OUT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digit_in  in  IN_W  digit code.
- digit_valid  in  1  digit_in is valid.
- digit_ready  out  1  block can take a digit this cycle.
- neg_toggle  in  1  one-cycle pulse that toggles the sign flag.
- commit  in  1  one-cycle pulse that finishes entry.
- clear  in  1  synchronous abort/clear.
- value_out  out  OUT_W  committed operand.
- value_valid  out  1  value_out is valid.
- value_ready  in  1  downstream accepts value_out.
- digit_count  out  $clog2(MAX_DIGITS+1)  digits accepted so far.
- neg  out  1  current sign flag.
- err  out  1  sticky: an overflow or illegal digit was rejected.

Behaviour:
Reset:
- rst_n low asynchronously forces: state IDLE, acc=0, digit_count=0, neg=0, err=0, value_out=0, value_valid=0.
- digit_ready is held at 0 while rst_n is low.

States:
- IDLE: no digits entered yet.
- ENTRY: at least one digit accepted.
- HOLD: value presented downstream.

digit_ready:
- Equals (state != HOLD) && (digit_count < MAX_DIGITS) && !clear.

Digit acceptance (digit_valid && digit_ready):
- digit ≥ RADIX: digit consumed, acc and count unchanged, err set.
- acc*RADIX+digit > LIMIT: digit consumed, acc and count unchanged, err set.
- Otherwise: acc updated, count+1, state goes to ENTRY.
- Intermediate product width is OUT_W+IN_W, so the multiply cannot wrap before the limit compare.

neg_toggle:
- In IDLE/ENTRY with SIGNED=1: neg inverts.
- Ignored in HOLD or when SIGNED=0.

commit (IDLE or ENTRY):
- Next edge: value_out = neg ? (~acc+1) : acc, value_valid=1, state HOLD.
- A digit accepted in the same cycle is included in the committed value.
- Commit with zero digits yields 0.
- Latency: commit to value_valid is 1 cycle.
- commit in HOLD is ignored.

HOLD:
- value_out and value_valid stay stable until value_valid && value_ready.
- On that handshake edge: value_valid=0, acc=0, count=0, neg=0, state IDLE.
- err is preserved across the handshake; only clear or reset drops it.
- Back-to-back operation: the next digit is accepted 1 cycle after the handshake.

clear:
- Highest priority, from any state.
- Next edge: IDLE, acc/count/neg/err/value_valid all 0, value_out=0.
- Overrides a simultaneous digit, commit or value handshake; any pending value is dropped.

Reset mid-operation:
- Any state returns immediately to the reset values; no partial value is emitted.

Decomposition:
- Shared package calc_pkg holds:
  - the state enum (IDLE, ENTRY, HOLD);
  - the default RADIX constant;
  - a function computing LIMIT from OUT_W and SIGNED.
- One combinational sub-module, radix_mac, computes acc*RADIX+digit.
  - Outputs: next_acc and a reject flag (overflow or illegal digit).
  - Reused by the planned hex/decimal display converter.

Test Plan:
(Defaults: IN_W=4, OUT_W=8, RADIX=10, MAX_DIGITS=3, SIGNED=1, value_ready=1.)
- Digits 1,2,7 then commit -> value_out=8'h7F for one cycle, one cycle after commit; digit_count=3 before commit; err=0.
- Digits 1,2,8 then commit -> 8 rejected, err=1, value_out=8'h0C; 4th digit offered with count=2 is still accepted if legal.
- neg_toggle, digits 5,0, commit -> value_out=8'hCE (-50), neg=1 until handshake, then 0.
- Digit 4'hA -> consumed, err=1, count unchanged; then digits 4,2, commit with value_ready low for 3 cycles -> value_out=8'h2A held stable, digit_ready=0 throughout, IDLE after handshake.
- Digits 9,9 then clear asserted together with commit -> no value_valid, acc=0, err=0, state IDLE next cycle.
- rst_n pulsed low for 2 ns mid-entry (between clock edges) -> all outputs 0 immediately; first digit after release accepted normally.
